// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - control word layout, NOP constant and pack/unpack helpers
package ctrl_pipe_pkg;

  localparam int CW_WIDTH_DEF = 19;

  localparam int W_PC_SEL     = 1;
  localparam int W_REG_WEN    = 1;
  localparam int W_A_SEL      = 1;
  localparam int W_B_SEL      = 1;
  localparam int W_MEM_RW     = 1;
  localparam int W_DATA_R_SEL = 3;
  localparam int W_IMM_SEL    = 3;
  localparam int W_DATA_W_SEL = 2;
  localparam int W_WB_SEL     = 2;
  localparam int W_ALU_SEL    = 4;

  // Field LSB positions; PCSel sits at the MSB.
  localparam int O_ALU_SEL    = 0;
  localparam int O_WB_SEL     = O_ALU_SEL + W_ALU_SEL;
  localparam int O_DATA_W_SEL = O_WB_SEL + W_WB_SEL;
  localparam int O_IMM_SEL    = O_DATA_W_SEL + W_DATA_W_SEL;
  localparam int O_DATA_R_SEL = O_IMM_SEL + W_IMM_SEL;
  localparam int O_MEM_RW     = O_DATA_R_SEL + W_DATA_R_SEL;
  localparam int O_B_SEL      = O_MEM_RW + W_MEM_RW;
  localparam int O_A_SEL      = O_B_SEL + W_B_SEL;
  localparam int O_REG_WEN    = O_A_SEL + W_A_SEL;
  localparam int O_PC_SEL     = O_REG_WEN + W_REG_WEN;

  localparam logic [CW_WIDTH_DEF-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic                    pc_sel;
    logic                    reg_wen;
    logic                    a_sel;
    logic                    b_sel;
    logic                    mem_rw;
    logic [W_DATA_R_SEL-1:0] data_r_sel;
    logic [W_IMM_SEL-1:0]    imm_sel;
    logic [W_DATA_W_SEL-1:0] data_w_sel;
    logic [W_WB_SEL-1:0]     wb_sel;
    logic [W_ALU_SEL-1:0]    alu_sel;
  } ctrl_t;

  function automatic logic [CW_WIDTH_DEF-1:0] ctrl_pack(input ctrl_t c);
    logic [CW_WIDTH_DEF-1:0] w;
    w = '0;
    w[O_PC_SEL]                              = c.pc_sel;
    w[O_REG_WEN]                             = c.reg_wen;
    w[O_A_SEL]                               = c.a_sel;
    w[O_B_SEL]                               = c.b_sel;
    w[O_MEM_RW]                              = c.mem_rw;
    w[O_DATA_R_SEL +: W_DATA_R_SEL]          = c.data_r_sel;
    w[O_IMM_SEL +: W_IMM_SEL]                = c.imm_sel;
    w[O_DATA_W_SEL +: W_DATA_W_SEL]          = c.data_w_sel;
    w[O_WB_SEL +: W_WB_SEL]                  = c.wb_sel;
    w[O_ALU_SEL +: W_ALU_SEL]                = c.alu_sel;
    return w;
  endfunction

  function automatic ctrl_t ctrl_unpack(input logic [CW_WIDTH_DEF-1:0] w);
    ctrl_t c;
    c.pc_sel     = w[O_PC_SEL];
    c.reg_wen    = w[O_REG_WEN];
    c.a_sel      = w[O_A_SEL];
    c.b_sel      = w[O_B_SEL];
    c.mem_rw     = w[O_MEM_RW];
    c.data_r_sel = w[O_DATA_R_SEL +: W_DATA_R_SEL];
    c.imm_sel    = w[O_IMM_SEL +: W_IMM_SEL];
    c.data_w_sel = w[O_DATA_W_SEL +: W_DATA_W_SEL];
    c.wb_sel     = w[O_WB_SEL +: W_WB_SEL];
    c.alu_sel    = w[O_ALU_SEL +: W_ALU_SEL];
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one elastic stage: valid bit, data register, optional parity bit
// Optional parity storage: CTRL_PIPE_PARITY_EN
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int                  CW_WIDTH = CW_WIDTH_DEF,
  parameter logic [CW_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic [CW_WIDTH-1:0] data_i,
`ifdef CTRL_PIPE_PARITY_EN
  input  logic                par_i,
  output logic                par_o,
`endif
  output logic                valid_o,
  output logic [CW_WIDTH-1:0] data_o
);

  logic                valid_q;
  logic [CW_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
    end
  end

  // Data only captures real words; a clear leaves it stale, the top masks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= NOP_WORD;
    end else if (load_i && valid_i) begin
      data_q <= data_i;
    end
  end

`ifdef CTRL_PIPE_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load_i && valid_i) begin
      par_q <= par_i;
    end
  end

  assign par_o = par_q;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - DEPTH-stage elastic control-word pipeline with flush and occupancy
// Optional parity protection and sticky parity_err port: CTRL_PIPE_PARITY_EN
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                  CW_WIDTH = CW_WIDTH_DEF,
  parameter int                  DEPTH    = 2,
  parameter logic [CW_WIDTH-1:0] NOP_WORD = CW_WIDTH'(CTRL_NOP)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CW_WIDTH-1:0]          in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CW_WIDTH-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef CTRL_PIPE_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]    stage_valid;
  logic [CW_WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]    move;
  logic [DEPTH-1:0]    load_en;
  logic                accept;
  logic                consume;
  logic [OW-1:0]       occ_q;
  logic [OW-1:0]       occ_d;

  // Walk from the output backwards: a stage can take a word if it is empty or its word leaves.
  always_comb begin
    logic take;
    take    = out_ready;
    move    = '0;
    load_en = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      move[i]    = stage_valid[i] & take;
      load_en[i] = ~stage_valid[i] | move[i];
      take       = load_en[i];
    end
  end

  assign in_ready = ~flush & load_en[0];
  assign accept   = in_valid & in_ready;
  assign consume  = move[DEPTH-1];

`ifdef CTRL_PIPE_PARITY_EN
  logic [DEPTH-1:0] stage_par;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                src_valid;
    logic [CW_WIDTH-1:0] src_data;
`ifdef CTRL_PIPE_PARITY_EN
    logic                src_par;
`endif
    if (i == 0) begin : g_head
      assign src_valid = accept;
      assign src_data  = in_ctrl;
`ifdef CTRL_PIPE_PARITY_EN
      assign src_par   = ^in_ctrl;
`endif
    end else begin : g_body
      assign src_valid = stage_valid[i-1];
      assign src_data  = stage_data[i-1];
`ifdef CTRL_PIPE_PARITY_EN
      assign src_par   = stage_par[i-1];
`endif
    end

    ctrl_pipe_stage #(
      .CW_WIDTH (CW_WIDTH),
      .NOP_WORD (NOP_WORD)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_en[i]),
      .clear_i (flush),
      .valid_i (src_valid),
      .data_i  (src_data),
`ifdef CTRL_PIPE_PARITY_EN
      .par_i   (src_par),
      .par_o   (stage_par[i]),
`endif
      .valid_o (stage_valid[i]),
      .data_o  (stage_data[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !consume) begin
      occ_d = occ_q + OW'(1);
    end else if (consume && !accept) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

`ifdef CTRL_PIPE_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (flush) begin
      par_err_q <= 1'b0;
    end else if (stage_valid[DEPTH-1] && ((^stage_data[DEPTH-1]) != stage_par[DEPTH-1])) begin
      par_err_q <= 1'b1;
    end
  end

  assign parity_err = par_err_q;
`endif

  assign out_valid = stage_valid[DEPTH-1];
  assign out_ctrl  = stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : NOP_WORD;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe (DEPTH=2)
module tb_ctrl_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_ctrl;
  logic [1:0]  occupancy;
`ifdef CTRL_PIPE_PARITY_EN
  logic        parity_err;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  ctrl_pipe #(.CW_WIDTH(19), .DEPTH(2), .NOP_WORD(19'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .occupancy  (occupancy)
`ifdef CTRL_PIPE_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 19'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back stream with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 19'h1A5A5;
    tick();
    chk("str_e1_valid", 32'(out_valid), 32'h0);
    chk("str_e1_occ", 32'(occupancy), 32'h1);
    in_ctrl = 19'h00F0F;
    tick();
    chk("str_e2_ctrl", 32'(out_ctrl), 32'h1A5A5);
    chk("str_e2_occ", 32'(occupancy), 32'h2);
    in_ctrl = 19'h7FFFF;
    tick();
    chk("str_e3_ctrl", 32'(out_ctrl), 32'h00F0F);
    chk("str_e3_occ", 32'(occupancy), 32'h2);
    in_valid = 1'b0;
    tick();
    chk("str_e4_ctrl", 32'(out_ctrl), 32'h7FFFF);
    chk("str_e4_occ", 32'(occupancy), 32'h1);
    tick();
    chk("str_e5_valid", 32'(out_valid), 32'h0);
    chk("str_e5_ctrl", 32'(out_ctrl), 32'h0);
    chk("str_e5_occ", 32'(occupancy), 32'h0);

    // Fill with out_ready low, then one-cycle release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 19'h0AAAA;
    tick();
    chk("fill_occ1", 32'(occupancy), 32'h1);
    in_ctrl = 19'h05555;
    tick();
    chk("fill_occ2", 32'(occupancy), 32'h2);
    chk("fill_out", 32'(out_ctrl), 32'h0AAAA);
    in_ctrl = 19'h12345;
    #1;
    chk("fill_in_ready0", 32'(in_ready), 32'h0);
    tick();
    chk("hold_out", 32'(out_ctrl), 32'h0AAAA);
    chk("hold_occ", 32'(occupancy), 32'h2);
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready1", 32'(in_ready), 32'h1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("rel_out", 32'(out_ctrl), 32'h05555);
    chk("rel_occ", 32'(occupancy), 32'h2);
    out_ready = 1'b1;
    tick();
    chk("drain1_out", 32'(out_ctrl), 32'h12345);
    chk("drain1_occ", 32'(occupancy), 32'h1);
    tick();
    chk("drain2_valid", 32'(out_valid), 32'h0);
    chk("drain2_occ", 32'(occupancy), 32'h0);

    // Bubble collapse under stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 19'h0F0F0;
    tick();
    in_valid = 1'b0;
    chk("bub_e1_valid", 32'(out_valid), 32'h0);
    chk("bub_e1_occ", 32'(occupancy), 32'h1);
    tick();
    chk("bub_e2_valid", 32'(out_valid), 32'h1);
    chk("bub_e2_ctrl", 32'(out_ctrl), 32'h0F0F0);
    chk("bub_e2_occ", 32'(occupancy), 32'h1);

    // Flush with a full pipe and a pending input
    in_valid = 1'b1;
    in_ctrl  = 19'h11111;
    tick();
    chk("pre_flush_occ", 32'(occupancy), 32'h2);
    flush   = 1'b1;
    in_ctrl = 19'h22222;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ctrl", 32'(out_ctrl), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'h0);
    tick();
    tick();
    chk("flush_noacc_valid", 32'(out_valid), 32'h0);
    chk("flush_noacc_occ", 32'(occupancy), 32'h0);

    // Asynchronous reset between edges
    in_valid = 1'b1;
    in_ctrl  = 19'h33333;
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_arst_occ", 32'(occupancy), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_occ", 32'(occupancy), 32'h0);
    chk("arst_ctrl", 32'(out_ctrl), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_arst_in_ready", 32'(in_ready), 32'h1);

`ifdef CTRL_PIPE_PARITY_EN
    in_valid = 1'b1;
    in_ctrl  = 19'h00001;
    tick();
    in_valid = 1'b0;
    tick();
    chk("par_clean", 32'(parity_err), 32'h0);
    force dut.g_stage[1].u_stage.data_q = 19'h00003;
    tick();
    release dut.g_stage[1].u_stage.data_q;
    chk("par_err_set", 32'(parity_err), 32'h1);
    tick();
    chk("par_err_sticky", 32'(parity_err), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("par_err_flush", 32'(parity_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised elastic pipeline for decoded RV32I control words. It replaces the single fixed flop stage between decoder and datapath with DEPTH stages, each carrying a valid bit. It adds valid/ready backpressure, bubble collapsing, flush and an occupancy count. When no valid word is at the output, it drives a safe NOP control word so the datapath never sees stale control.

Parameters:
CW_WIDTH, 19, control word width (PCSel, RegWEn, ASel, BSel, MemRW, DataRSel[3], ImmSel[3], DataWSel[2], WBSel[2], ALUSel[4], packed MSB-first in that order)
DEPTH, 2, number of pipeline stages; legal range 1..8
NOP_WORD, 19'h0, control word driven on out_ctrl while out_valid=0 (RegWEn=0, MemRW=0, PCSel=0)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight words
in_valid  input  1  decoder presents a control word
in_ready  output  1  pipeline accepts in_ctrl this cycle
in_ctrl  input  CW_WIDTH  packed control word from decoder
out_valid  output  1  last stage holds a valid word
out_ready  input  1  datapath consumes the output word this cycle
out_ctrl  output  CW_WIDTH  last-stage word when out_valid=1, else NOP_WORD
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits are 0 and all stage data is NOP_WORD. Outputs: out_valid=0, out_ctrl=NOP_WORD, occupancy=0. in_ready=1 as soon as rst_n is high and flush=0.
- Stage i is 0..DEPTH-1; stage DEPTH-1 drives the output.
- move[DEPTH-1] = v[DEPTH-1] & out_ready.
- move[i] = v[i] & (~v[i+1] | move[i+1]).
- A stage loads from its predecessor, or from in_ctrl for stage 0, when it is empty or moving out.
- Bubble collapse: a valid word advances into any empty downstream stage even while the output is stalled.
- in_ready = ~flush & (~v[0] | move[0]). A word is accepted when in_valid & in_ready.
- Latency with out_ready held high: a word accepted at edge N appears at out_valid at edge N+DEPTH-1, i.e. it is registered DEPTH times. Throughput is 1 word/cycle.
- Full pipeline with out_ready=0: in_ready=0 and all contents hold unchanged. in_ctrl is ignored.
- Simultaneous consume and accept on a full pipe: both happen, and occupancy is unchanged.
- Occupancy changes by +1 on accept-only, by -1 on consume-only, and by 0 otherwise. It never exceeds DEPTH and never underflows.
- flush=1 at an edge has these effects:
  - all valid bits clear and occupancy goes to 0;
  - the input word in that cycle is not accepted, because in_ready is forced to 0;
  - a same-cycle output handshake still counts as consumed by the datapath;
  - stage data may keep stale values, but out_ctrl must show NOP_WORD.
- out_ctrl = v[DEPTH-1] ? data[DEPTH-1] : NOP_WORD. This is combinational from registered state only, with no in_* to out_* combinational path. in_ready depends combinationally on out_ready.
- rst_n asserted mid-stream discards all words immediately, with no wait for a clock edge.

Optional Feature:
Macro: CTRL_PIPE_PARITY_EN
- With the macro defined:
  - each stage stores an extra even-parity bit computed from in_ctrl at acceptance;
  - the output-side check compares the recomputed parity of data[DEPTH-1] with the stored bit whenever out_valid=1;
  - a mismatch sets the sticky output parity_err (1 bit), which clears only on reset or flush.
- Without the macro: no parity storage, and the parity_err port does not exist.

Decomposition:
- Shared package ctrl_pipe_pkg holds:
  - field widths and bit offsets of each control field within the packed word;
  - CW_WIDTH_DEF = 19 and the NOP constant;
  - a pack/unpack function pair so decoder and datapath use identical ordering.
- One sub-module, ctrl_pipe_stage: the valid bit, the data register and the optional parity bit, with a load enable and a clear input. ctrl_pipe instantiates DEPTH of them in a generate loop and holds the move/ready chain plus the occupancy counter.

Test Plan:
- Reset, then DEPTH=2: accept words 0x1A5A5, 0x00F0F and 0x7FFFF back-to-back with out_ready=1 -> each appears on out_ctrl 2 cycles later in order; occupancy is steady at 2.
- Fill the pipe with out_ready=0 -> after 2 accepts in_ready=0 and occupancy=2. A third in_ctrl (0x12345) is held off. Raise out_ready for one cycle -> exactly one word is consumed and 0x12345 is accepted in the same cycle.
- Bubble collapse: accept one word while out_ready=0 -> it reaches the last stage at the next edge, out_valid=1 and occupancy=1.
- Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=NOP_WORD (0x00000), occupancy=0; the flushed-cycle input is not accepted.
- Assert rst_n low mid-stream between edges -> out_valid=0 and occupancy=0 immediately, with no clock edge.
- With CTRL_PIPE_PARITY_EN defined, force one bit of the last-stage data -> parity_err=1 and it stays 1 until flush.
